// File: rtl/stream_width_packer.sv
// Packs RATIO narrow stream beats (LSB lane first) into one wide output word.
// A tlast beat closes the word early; unused lanes are zero with tkeep cleared.
module stream_width_packer #(
    parameter int DWIDTH = 32,
    parameter int RATIO  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DWIDTH-1:0]         s_in_tdata,
    input  logic                      s_in_tvalid,
    input  logic                      s_in_tlast,
    output logic                      s_in_tready,
    output logic [DWIDTH*RATIO-1:0]   m_out_tdata,
    output logic [RATIO-1:0]          m_out_tkeep,
    output logic                      m_out_tlast,
    output logic                      m_out_tvalid,
    input  logic                      m_out_tready
);

    localparam int IW = $clog2(RATIO);
    localparam int WW = DWIDTH * RATIO;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_VALID = 1'b1
    } out_state_t;

    out_state_t              r_state;
    logic [IW-1:0]           r_idx;
    logic [WW-1:0]           r_asm_data;
    logic [RATIO-1:0]        r_asm_keep;
    logic [WW-1:0]           r_out_data;
    logic [RATIO-1:0]        r_out_keep;
    logic                    r_out_last;

    logic                    w_accept;
    logic                    w_transfer;
    logic                    w_complete;
    logic [WW-1:0]           w_next_data;
    logic [RATIO-1:0]        w_next_keep;

    // Handshake: a beat moves on a side only in a cycle where valid and ready
    // are both high; valid never depends on ready, and once raised, valid and
    // payload stay put until that transfer happens.
    assign s_in_tready  = rst_n & ((r_state == ST_EMPTY) | m_out_tready);
    assign w_accept     = s_in_tvalid & s_in_tready;
    assign w_transfer   = (r_state == ST_VALID) & m_out_tready;
    assign w_complete   = w_accept & ((r_idx == IW'(RATIO - 1)) | s_in_tlast);

    assign m_out_tvalid = (r_state == ST_VALID);
    assign m_out_tdata  = r_out_data;
    assign m_out_tkeep  = r_out_keep;
    assign m_out_tlast  = r_out_last;

    // Assembly contents as they would look with the current beat merged in.
    always_comb begin
        w_next_data = r_asm_data;
        w_next_data[int'(r_idx)*DWIDTH +: DWIDTH] = s_in_tdata;
        w_next_keep = r_asm_keep | (RATIO'(1) << r_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_idx      <= '0;
            r_asm_data <= '0;
            r_asm_keep <= '0;
            r_out_data <= '0;
            r_out_keep <= '0;
            r_out_last <= 1'b0;
        end else begin
            if (w_complete) begin
                // Accept while VALID implies a simultaneous transfer, so the
                // output register is always free to be overwritten here.
                r_state    <= ST_VALID;
                r_out_data <= w_next_data;
                r_out_keep <= w_next_keep;
                r_out_last <= s_in_tlast;
                r_asm_data <= '0;
                r_asm_keep <= '0;
                r_idx      <= '0;
            end else begin
                if (w_accept) begin
                    r_asm_data <= w_next_data;
                    r_asm_keep <= w_next_keep;
                    r_idx      <= r_idx + IW'(1);
                end
                if (w_transfer) begin
                    r_state <= ST_EMPTY;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_width_packer.sv
// Randomized bench for stream_width_packer: packet-level reference model,
// in-order scoreboard on the wide output, plus directed latency/stall/reset cases.
module tb_stream_width_packer;

    localparam int DW = 32;
    localparam int R  = 4;
    localparam int W  = DW * R;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s_in_tdata;
    logic          s_in_tvalid;
    logic          s_in_tlast;
    logic          s_in_tready;
    logic [W-1:0]  m_out_tdata;
    logic [R-1:0]  m_out_tkeep;
    logic          m_out_tlast;
    logic          m_out_tvalid;
    logic          m_out_tready;

    stream_width_packer #(.DWIDTH(DW), .RATIO(R)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_in_tdata   (s_in_tdata),
        .s_in_tvalid  (s_in_tvalid),
        .s_in_tlast   (s_in_tlast),
        .s_in_tready  (s_in_tready),
        .m_out_tdata  (m_out_tdata),
        .m_out_tkeep  (m_out_tkeep),
        .m_out_tlast  (m_out_tlast),
        .m_out_tvalid (m_out_tvalid),
        .m_out_tready (m_out_tready)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    logic [W-1:0]  exp_q[$];
    logic [R-1:0]  exp_keep_q[$];
    logic          exp_last_q[$];
    logic [DW-1:0] pkt[$];
    int            n_checks;
    int            n_errors;
    bit            rand_ready;
    bit            mon_en;
    bit            prev_stall;
    logic [W-1:0]  prev_data;
    logic [R-1:0]  prev_keep;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a packet of n beats splits into ceil(n/R) words,
    // each word taking the next R beats, only the final one flagged last.
    task automatic model_packet();
        int n;
        n = pkt.size();
        for (int w = 0; w * R < n; w++) begin
            logic [W-1:0] word;
            logic [R-1:0] keep;
            word = '0;
            keep = '0;
            for (int k = 0; k < R; k++) begin
                if (w * R + k < n) begin
                    word[k*DW +: DW] = pkt[w*R + k];
                    keep[k] = 1'b1;
                end
            end
            exp_q.push_back(word);
            exp_keep_q.push_back(keep);
            exp_last_q.push_back((w + 1) * R >= n);
        end
    endtask

    // Driver: present one beat from a negedge, hold until accepted.
    task automatic send_beat(input logic [DW-1:0] data, input logic last);
        int waited;
        @(negedge clk);
        s_in_tvalid = 1'b1;
        s_in_tdata  = data;
        s_in_tlast  = last;
        #1;
        waited = 0;
        while (!s_in_tready && waited < 300) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!s_in_tready) begin
            check("ready_timeout", 0, 1);
            s_in_tvalid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            s_in_tvalid = 1'b0;
            s_in_tlast  = 1'($urandom_range(0, 1));
            s_in_tdata  = $urandom;
        end
    endtask

    task automatic send_pkt();
        model_packet();
        for (int i = 0; i < pkt.size(); i++) send_beat(pkt[i], i == pkt.size() - 1);
    endtask

    task automatic rand_pkt(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back($urandom);
        send_pkt();
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 500 && (exp_q.size() != 0 || m_out_tvalid); i++) @(negedge clk);
        @(negedge clk);
        check("drain_left", W'(exp_q.size()), 0);
    endtask

    // Output monitor: random backpressure, hold-stability and in-order compare.
    always begin
        @(negedge clk);
        if (rand_ready) m_out_tready = 1'($urandom_range(0, 1));
        #1;
        if (mon_en) begin
            if (prev_stall) begin
                check("hold_valid", W'(m_out_tvalid), 1);
                check("hold_data", m_out_tdata, prev_data);
                check("hold_keep", W'(m_out_tkeep), W'(prev_keep));
            end
            if (m_out_tvalid && m_out_tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", m_out_tdata, 0);
                end else begin
                    check("word_data", m_out_tdata, exp_q.pop_front());
                    check("word_keep", W'(m_out_tkeep), W'(exp_keep_q.pop_front()));
                    check("word_last", W'(m_out_tlast), W'(exp_last_q.pop_front()));
                end
            end
            prev_stall = m_out_tvalid && !m_out_tready;
            prev_data  = m_out_tdata;
            prev_keep  = m_out_tkeep;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rand_ready   = 1'b0;
        mon_en       = 1'b0;
        prev_stall   = 1'b0;
        rst_n        = 1'b0;
        s_in_tvalid  = 1'b0;
        s_in_tlast   = 1'b0;
        s_in_tdata   = '0;
        m_out_tready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_tvalid", W'(m_out_tvalid), 0);
        check("rst_tdata", m_out_tdata, 0);
        check("rst_tkeep", W'(m_out_tkeep), 0);
        check("rst_tlast", W'(m_out_tlast), 0);
        check("rst_in_ready", W'(s_in_tready), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Full word, back-to-back, latency of exactly one cycle
        pkt = '{32'h11, 32'h22, 32'h33, 32'h44};
        model_packet();
        send_beat(32'h11, 1'b0);
        send_beat(32'h22, 1'b0);
        send_beat(32'h33, 1'b0);
        check("lat_early", W'(m_out_tvalid), 0);
        send_beat(32'h44, 1'b1);
        check("lat_valid", W'(m_out_tvalid), 1);
        check("t1_data", m_out_tdata, 128'h00000044_00000033_00000022_00000011);
        check("t1_keep", W'(m_out_tkeep), W'(4'b1111));
        check("t1_last", W'(m_out_tlast), 1);
        wait_drain();

        // Six-beat packet -> full word then a two-lane tail
        pkt = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
        send_pkt();
        check("t2_tail_data", m_out_tdata, 128'h00000000_00000000_00000006_00000005);
        check("t2_tail_keep", W'(m_out_tkeep), W'(4'b0011));
        wait_drain();

        // Single-beat packet, then the next beat must start at lane 0
        pkt = '{32'hAB};
        send_pkt();
        check("t3_data", m_out_tdata, 128'hAB);
        check("t3_keep", W'(m_out_tkeep), W'(4'b0001));
        check("t3_last", W'(m_out_tlast), 1);
        pkt = '{32'h77, 32'h88};
        send_pkt();
        check("t3_lane0", m_out_tdata, 128'h00000088_00000077);
        wait_drain();

        // Stall with a completing beat waiting, then release with no bubble
        m_out_tready = 1'b0;
        pkt = '{32'hAB};
        send_pkt();
        pkt = '{32'hCD};
        model_packet();
        @(negedge clk);
        s_in_tvalid = 1'b1;
        s_in_tdata  = 32'hCD;
        s_in_tlast  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("stall_in_ready", W'(s_in_tready), 0);
            check("stall_valid", W'(m_out_tvalid), 1);
            check("stall_data", m_out_tdata, 128'hAB);
            @(negedge clk);
        end
        m_out_tready = 1'b1;
        #1;
        check("release_in_ready", W'(s_in_tready), 1);
        @(posedge clk);
        #1;
        s_in_tvalid = 1'b0;
        check("nogap_valid", W'(m_out_tvalid), 1);
        check("nogap_data", m_out_tdata, 128'hCD);
        wait_drain();

        // Random backpressure: 64-beat stream then random-length packets
        rand_ready = 1'b1;
        rand_pkt(64);
        for (int p = 0; p < 8; p++) rand_pkt($urandom_range(1, 10));
        wait_drain();
        rand_ready   = 1'b0;
        m_out_tready = 1'b1;

        // Asynchronous reset in the middle of a word
        send_beat(32'hDEAD0001, 1'b0);
        send_beat(32'hDEAD0002, 1'b0);
        mon_en = 1'b0;
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_tvalid", W'(m_out_tvalid), 0);
        check("arst_tdata", m_out_tdata, 0);
        check("arst_tkeep", W'(m_out_tkeep), 0);
        check("arst_tlast", W'(m_out_tlast), 0);
        check("arst_in_ready", W'(s_in_tready), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        pkt = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};
        send_pkt();
        check("post_rst_data", m_out_tdata, 128'h000000A4_000000A3_000000A2_000000A1);
        check("post_rst_keep", W'(m_out_tkeep), W'(4'b1111));
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
